seven_seg_mux: RTL and testbench

//  Time-multiplexed driver for an NUM_DIGITS-digit common-anode hex seven-segment display.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_mux_hex_to_seg.sv | 15 +
 rtl/seven_seg_mux.sv | 132 +++++++++++++
 tb/tb_seven_seg_mux.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment driver.
// Glyphs are stored active-high in {g,f,e,d,c,b,a} order; pin polarity
// is applied by the consumer.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    // Hex glyphs 0..F, active-high, bit 0 = segment a.
    localparam seg_t HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seven_seg_mux_hex_to_seg.sv
// Combinational nibble to active-high seven-segment glyph lookup.
// Total over 0..F, so there is no invalid input and no X output.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    // Table lookup of the glyph for this nibble.
    always_comb begin
        seg = HEX_SEG[nib];
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed driver for a NUM_DIGITS-digit hex seven-segment display.
// A prescaler divides clk into digit slots; each slot starts with one guard
// cycle (all dark) to avoid ghosting while the anode switches. Data is taken
// from a shadow register captured on load, so the producer may change value
// freely between loads. All pin outputs are registered (1-cycle latency).
// Optional feature: define SEG_LZB_EN for leading-zero blanking.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         dp,
    input  logic                          blank,
    output logic [6:0]                    seg,
    output logic                          seg_dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // XOR masks that convert active-high internal values to pin polarity.
    localparam seg_t                  SEG_INV = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_INV  = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]           presc;
    logic                    guard;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   dp_sh;

    logic                    presc_wrap;
    logic [3:0]              sel_nib;
    seg_t                    sel_glyph;
    logic [NUM_DIGITS-1:0]   suppress;
    logic                    lit;
    seg_t                    seg_raw;
    logic                    dp_raw;
    logic [NUM_DIGITS-1:0]   an_raw;

    assign presc_wrap = (presc == PRESC_LAST);
    assign sel_nib    = shadow[int'(digit_idx)*4 +: 4];

    hex_to_seg u_hex_to_seg (
        .nib (sel_nib),
        .seg (sel_glyph)
    );

    // Scan timing: prescaler, digit slot counter and the one-cycle guard flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            digit_idx <= '0;
            guard     <= 1'b0;
        end else begin
            guard <= presc_wrap;
            if (presc_wrap) begin
                presc     <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Shadow capture of display data; independent of scan position.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            dp_sh  <= '0;
        end else if (load) begin
            shadow <= value;
            dp_sh  <= dp;
        end
    end

    // Per-digit suppression mask (leading zeros when the feature is built in).
    always_comb begin
        suppress = '0;
`ifdef SEG_LZB_EN
        begin
            logic higher_zero;
            higher_zero = 1'b1;
            // Walk down from the top digit; a digit stays suppressible only
            // while it and every digit above it hold zero. Digit 0 never is.
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                higher_zero = higher_zero && (shadow[i*4 +: 4] == 4'h0);
                suppress[i] = higher_zero && !dp_sh[i];
            end
        end
`endif
    end

    // Active-high view of what the pins should show this cycle.
    always_comb begin
        lit     = !guard && !blank && !suppress[digit_idx];
        seg_raw = lit ? sel_glyph : SEG_OFF;
        dp_raw  = lit ? dp_sh[digit_idx] : 1'b0;
        an_raw  = lit ? (NUM_DIGITS'(1) << digit_idx) : '0;
    end

    // Registered pin drivers with polarity applied; dark in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg    <= SEG_OFF ^ SEG_INV;
            seg_dp <= DP_INV;
            an     <= AN_INV;
        end else begin
            seg    <= seg_raw ^ SEG_INV;
            seg_dp <= dp_raw ^ DP_INV;
            an     <= an_raw ^ AN_INV;
        end
    end

    // Simulation checks: legal divider and never more than one digit enabled.
    a_scan_div : assert property (@(posedge clk) SCAN_DIV >= 2);
    a_an_onehot : assert property (@(posedge clk) disable iff (reset)
                                   $onehot0(an ^ AN_INV));

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux with NUM_DIGITS=4, SCAN_DIV=4, active-low
// segments and anodes. Inputs are driven and outputs sampled on the falling
// edge; edge_n counts rising edges since the last reset release.
module tb_seven_seg_mux;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    int n_checks;
    int n_fail;
    int edge_n;

    // Expected pin words {an[3:0], seg[6:0], seg_dp}, one per output cycle.
    logic [11:0] exp_q[$];

    localparam logic [11:0] W_OFF   = {4'b1111, 7'b1111111, 1'b1};
    // Scan pattern for value 16'h1A2F, dp 4'b0100.
    localparam logic [11:0] W_D0_F  = {4'b1110, 7'b0001110, 1'b1};
    localparam logic [11:0] W_D1_2  = {4'b1101, 7'b0100100, 1'b1};
    localparam logic [11:0] W_D2_AP = {4'b1011, 7'b0001000, 1'b0};
    localparam logic [11:0] W_D3_1  = {4'b0111, 7'b1111001, 1'b1};
    // Zero / three / five glyphs on various digits.
    localparam logic [11:0] W_D0_0  = {4'b1110, 7'b1000000, 1'b1};
    localparam logic [11:0] W_D1_0  = {4'b1101, 7'b1000000, 1'b1};
    localparam logic [11:0] W_D2_0  = {4'b1011, 7'b1000000, 1'b1};
    localparam logic [11:0] W_D3_0  = {4'b0111, 7'b1000000, 1'b1};
    localparam logic [11:0] W_D3_0P = {4'b0111, 7'b1000000, 1'b0};
    localparam logic [11:0] W_D0_3  = {4'b1110, 7'b0110000, 1'b1};
    localparam logic [11:0] W_D1_5  = {4'b1101, 7'b0010010, 1'b1};

    seven_seg_mux #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_AN  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .dp        (dp),
        .blank     (blank),
        .seg       (seg),
        .seg_dp    (seg_dp),
        .an        (an),
        .digit_idx (digit_idx)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(negedge clk);
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) step();
    endtask

    task automatic push_slot(input logic [11:0] w);
        exp_q.push_back(W_OFF);
        repeat (3) exp_q.push_back(w);
    endtask

    // Step once per queued word and compare pins against it.
    task automatic drain(input string tag);
        logic [11:0] e;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check_eq($sformatf("%s_e%0d", tag, edge_n), {20'd0, an, seg, seg_dp},
                     {20'd0, e});
        end
    endtask

    task automatic load_data(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;
        reset    = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        blank    = 1'b0;

        // 1: reset held, then first edge after release shows digit 0 = "0".
        repeat (3) @(negedge clk);
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_dp", 32'(seg_dp), 32'h1);
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_idx", 32'(digit_idx), 32'h0);
        reset  = 1'b0;
        edge_n = 0;
        step();
        check_eq("rel_an", 32'(an), 32'hE);
        check_eq("rel_seg", 32'(seg), 32'h40);

        // 2: scan pattern for 1A2F / dp on digit 2, two full passes.
        load_data(16'h1A2F, 4'b0100);
        run_to(16);
        repeat (2) begin
            push_slot(W_D0_F);
            push_slot(W_D1_2);
            push_slot(W_D2_AP);
            push_slot(W_D3_1);
        end
        drain("scan");
        check_eq("scan_idx", 32'(digit_idx), 32'h0);

        // 3: load on the wrap edge into digit 1 (edge 52).
        run_to(51);
        value = 16'h0003;
        dp    = 4'b0000;
        load  = 1'b1;
        exp_q.push_back(W_D0_F);
        push_slot(W_D1_0);
        push_slot(W_D2_0);
        push_slot(W_D3_0);
        push_slot(W_D0_3);
        step();
        load = 1'b0;
        check_eq("wrap_e52", {20'd0, an, seg, seg_dp}, {20'd0, exp_q.pop_front()});
        drain("wrap");

        // 4: blank for edges 69..74; scan keeps its phase.
        blank = 1'b1;
        repeat (6) exp_q.push_back(W_OFF);
        repeat (5) begin
            step();
            check_eq($sformatf("blank_e%0d", edge_n), {20'd0, an, seg, seg_dp},
                     {20'd0, exp_q.pop_front()});
        end
        step();
        blank = 1'b0;
        check_eq("blank_e74", {20'd0, an, seg, seg_dp}, {20'd0, exp_q.pop_front()});
        check_eq("blank_idx", 32'(digit_idx), 32'h2);
        exp_q.push_back(W_D2_0);
        exp_q.push_back(W_D2_0);
        push_slot(W_D3_0);
        drain("resume");

        // 5: reset asserted during the digit 2 slot (edges 89..92).
        run_to(90);
        check_eq("pre_rst_an", 32'(an), 32'hB);
        reset = 1'b1;
        step();
        check_eq("mid_rst_an", 32'(an), 32'hF);
        check_eq("mid_rst_seg", 32'(seg), 32'h7F);
        check_eq("mid_rst_idx", 32'(digit_idx), 32'h0);
        reset  = 1'b0;
        edge_n = 0;
        step();
        check_eq("post_rst_an", 32'(an), 32'hE);
        check_eq("post_rst_seg", 32'(seg), 32'h40);

        // 6: leading zeros for 0050, then with the dp on digit 3.
        load_data(16'h0050, 4'b0000);
        run_to(16);
        push_slot(W_D0_0);
        push_slot(W_D1_5);
`ifdef SEG_LZB_EN
        repeat (8) exp_q.push_back(W_OFF);
`else
        push_slot(W_D2_0);
        push_slot(W_D3_0);
`endif
        drain("lz");
        value = 16'h0050;
        dp    = 4'b1000;
        load  = 1'b1;
        exp_q.push_back(W_OFF);
        repeat (3) exp_q.push_back(W_D0_0);
        push_slot(W_D1_5);
`ifdef SEG_LZB_EN
        repeat (4) exp_q.push_back(W_OFF);
`else
        push_slot(W_D2_0);
`endif
        push_slot(W_D3_0P);
        step();
        load = 1'b0;
        check_eq("lzdp_e33", {20'd0, an, seg, seg_dp}, {20'd0, exp_q.pop_front()});
        drain("lzdp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
